axis_upsizer: RTL and testbench

Synthesizable AXI-Stream width upconverter. It accepts a stream of WORD_W-bit words on a subordinate port and packs WORDS_PER_BEAT consecutive words into one BUS_W-bit beat on a manager port. It flags the last beat of every N_BEATS-beat packet. It sits between the word-level stream source and the bus-level stream sink, and is exercised by the team's AXIS TX/RX verification components on both sides.

---
 rtl/axis_upsizer.sv | 97 +++++++++
 tb/tb_axis_upsizer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_upsizer.sv
// rtl/axis_upsizer.sv - AXI-Stream width upconverter packing WORD_W words into BUS_W beats
// Word k of a beat lands in slice k; m_last marks beat N_BEATS-1 of every packet.
module axis_upsizer #(
  parameter int WORD_W  = 8,
  parameter int BUS_W   = 32,
  parameter int N_BEATS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BUS_W-1:0]  m_data,
  output logic              m_last
);

  localparam int WORDS_PER_BEAT = BUS_W / WORD_W;
  localparam int WCNT_W = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;
  localparam int BCNT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WORDS_PER_BEAT - 1);
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(N_BEATS - 1);

  generate
    if ((BUS_W % WORD_W) != 0 || BUS_W < WORD_W) begin : g_bad_width
      $fatal(1, "axis_upsizer: BUS_W must be an integer multiple of WORD_W");
    end
    if (N_BEATS < 1) begin : g_bad_beats
      $fatal(1, "axis_upsizer: N_BEATS must be at least 1");
    end
  endgenerate

  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] pack_q, pack_d, beat;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [BUS_W-1:0]  m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic              m_valid_q, m_valid_d;
  logic              accept;

  // Only the completing word has to wait for the output register to free up.
  assign s_ready = (wcnt_q != WCNT_MAX) | ~m_valid_q | m_ready;
  assign accept  = s_valid & s_ready;

  always_comb begin
    pack_d    = pack_q;
    wcnt_d    = wcnt_q;
    bcnt_d    = bcnt_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;
    beat      = pack_q;
    beat[WORDS_PER_BEAT-1] = s_data;

    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    if (accept) begin
      if (wcnt_q == WCNT_MAX) begin
        // A completion on the same edge as a transfer overrides the clear above.
        m_data_d  = beat;
        m_valid_d = 1'b1;
        m_last_d  = (bcnt_q == BCNT_MAX);
        wcnt_d    = '0;
        bcnt_d    = (bcnt_q == BCNT_MAX) ? '0 : bcnt_q + BCNT_W'(1);
      end else begin
        pack_d[wcnt_q] = s_data;
        wcnt_d         = wcnt_q + WCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack_q    <= '0;
      wcnt_q    <= '0;
      bcnt_q    <= '0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      pack_q    <= pack_d;
      wcnt_q    <= wcnt_d;
      bcnt_q    <= bcnt_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_axis_upsizer.sv
// tb/tb_axis_upsizer.sv - scoreboard bench for axis_upsizer (WORD_W=8, BUS_W=32, N_BEATS=2)
module tb_axis_upsizer;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_total = 0;
  int    n_pass  = 0;
  bit    rand_mode = 1'b0;

  axis_upsizer #(.WORD_W(8), .BUS_W(32), .N_BEATS(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: a transfer happens at the posedge following a negedge with m_valid & m_ready.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beat: got %h last=%b, expected none", m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", m_data, e.data);
          check("beat_last", {31'd0, m_last}, {31'd0, e.last});
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) m_ready = ($urandom_range(0, 9) < 3);
    end
  end

  task automatic expect_beat(input logic [31:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // Called at posedge+1; returns at posedge+1 after the word was accepted.
  task automatic push_word(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL push_timeout: word %h not accepted, expected acceptance", d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_rand(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    s_data = d;
    for (int n = 0; n < 2000; n++) begin
      s_valid = ($urandom_range(0, 9) < 3);
      @(negedge clk);
      ok = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    s_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL rand_push_timeout: word %h not accepted, expected acceptance", d);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    rst     = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", m_data, 32'h0000_0000);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Streaming
    m_ready = 1'b1;
    expect_beat(32'h4433_2211, 1'b0);
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    s_valid = 1'b0;
    check("stream_valid_on", {31'd0, m_valid}, 32'd1);
    check("stream_data", m_data, 32'h4433_2211);
    @(posedge clk);
    #1;
    check("stream_valid_off", {31'd0, m_valid}, 32'd0);

    // Packet framing
    do_reset();
    expect_beat(32'h0302_0100, 1'b0);
    expect_beat(32'h0706_0504, 1'b1);
    expect_beat(32'h0B0A_0908, 1'b0);
    expect_beat(32'h0F0E_0D0C, 1'b1);
    for (int i = 0; i < 16; i++) push_word(8'(i));
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Backpressure
    do_reset();
    m_ready = 1'b0;
    expect_beat(32'hA3A2_A1A0, 1'b0);
    expect_beat(32'hA7A6_A5A4, 1'b1);
    for (int i = 0; i < 7; i++) push_word(8'hA0 + 8'(i));
    s_data = 8'hA7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_s_ready_low", {31'd0, s_ready}, 32'd0);
      check("bp_valid_held", {31'd0, m_valid}, 32'd1);
      check("bp_data_held", m_data, 32'hA3A2_A1A0);
      check("bp_last_held", {31'd0, m_last}, 32'd0);
    end
    @(posedge clk);
    #1 m_ready = 1'b1;
    #1;
    check("bp_s_ready_comb", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("bp_no_bubble_valid", {31'd0, m_valid}, 32'd1);
    check("bp_no_bubble_data", m_data, 32'hA7A6_A5A4);
    @(posedge clk);
    #1;
    check("bp_drained", {31'd0, m_valid}, 32'd0);

    // Reset mid-operation: bcnt=1 and two stale words pending
    expect_beat(32'hD3D2_D1D0, 1'b0);
    for (int i = 0; i < 4; i++) push_word(8'hD0 + 8'(i));
    push_word(8'h55);
    push_word(8'h66);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    check("mid_rst_data", m_data, 32'h0000_0000);
    check("mid_rst_last", {31'd0, m_last}, 32'd0);
    check("mid_rst_s_ready", {31'd0, s_ready}, 32'd1);
    #2 rst = 1'b0;
    expect_beat(32'h0403_0201, 1'b0);
    for (int i = 1; i <= 4; i++) push_word(8'(i));
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_queue_empty", exp_q.size(), 32'd0);

    // Random traffic, 50 packets
    do_reset();
    rand_mode = 1'b1;
    for (int p = 0; p < 50; p++) begin
      for (int b = 0; b < 2; b++) begin
        w = $urandom;
        expect_beat(w, (b == 1));
        for (int k = 0; k < 4; k++) push_rand(w[8*k +: 8]);
      end
    end
    for (int n = 0; n < 5000 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    rand_mode = 1'b0;
    check("rand_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
